// File: rtl/timer_counter01.sv
// rtl/timer_counter01.sv - dual 8051 timer/counter (T0, T1) with TMOD/TCON and counter SFRs
module timer_counter01 #(
    parameter logic [7:0] ADDR_TCON = 8'h88,
    parameter logic [7:0] ADDR_TMOD = 8'h89,
    parameter logic [7:0] ADDR_TL0  = 8'h8A,
    parameter logic [7:0] ADDR_TL1  = 8'h8B,
    parameter logic [7:0] ADDR_TH0  = 8'h8C,
    parameter logic [7:0] ADDR_TH1  = 8'h8D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       t0_pin,
    input  logic       t1_pin,
    input  logic       int0_n,
    input  logic       int1_n,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    input  logic       sfr_we,
    output logic [7:0] sfr_rdata,
    input  logic       int_ack0,
    input  logic       int_ack1,
    output logic [7:0] tcon,
    output logic [7:0] tmod,
    output logic       t1_ovf
);

    logic [7:0] tcon_r, tmod_r, tl0, th0, tl1, th1;
    logic [1:0] t0_s, t1_s, i0_s, i1_s;
    logic       t0_prev, t1_prev;

    // Returns {overflow, next TH, next TL} for one increment in mode m.
    function automatic logic [16:0] step(input logic [1:0] m, input logic [7:0] tl, input logic [7:0] th);
        logic [5:0]  lo;
        logic [8:0]  hi;
        logic [16:0] r;
        lo = 6'd0;
        hi = 9'd0;
        case (m)
            2'd0: begin
                lo = {1'b0, tl[4:0]} + 6'd1;
                hi = lo[5] ? ({1'b0, th} + 9'd1) : {1'b0, th};
                r  = {hi[8], hi[7:0], tl[7:5], lo[4:0]};
            end
            2'd1: r = {1'b0, th, tl} + 17'd1;
            2'd2: r = (tl == 8'hFF) ? {1'b1, th, th} : {1'b0, th, tl + 8'd1};
            default: r = {tl == 8'hFF, th, tl + 8'd1};
        endcase
        return r;
    endfunction

    logic [1:0]  m0, m1;
    logic        t0_m3, tr0, tr1;
    logic        cnt_ev0, cnt_ev1, run0, run1, inc0, inc1;
    logic        t0_wr, t1_wr, tcon_wr, th0_inc;
    logic        ovf0, ovf1, th0_ovf, tf0_nxt, tf1_nxt;
    logic [16:0] s0, s1;

    assign m0      = tmod_r[1:0];
    assign m1      = tmod_r[5:4];
    assign t0_m3   = (m0 == 2'd3);
    assign tr0     = tcon_r[4];
    assign tr1     = tcon_r[6];
    assign cnt_ev0 = tick & t0_prev & ~t0_s[1];
    assign cnt_ev1 = tick & t1_prev & ~t1_s[1];
    assign run0    = tr0 & (~tmod_r[3] | i0_s[1]);
    assign run1    = tr1 & (~tmod_r[7] | i1_s[1]);
    assign t0_wr   = sfr_we & ((sfr_addr == ADDR_TL0) | (sfr_addr == ADDR_TH0));
    assign t1_wr   = sfr_we & ((sfr_addr == ADDR_TL1) | (sfr_addr == ADDR_TH1));
    assign tcon_wr = sfr_we & (sfr_addr == ADDR_TCON);
    // A write to either byte of a timer freezes the whole timer for that cycle.
    assign inc0    = run0 & (tmod_r[2] ? cnt_ev0 : tick) & ~t0_wr;
    assign inc1    = run1 & (tmod_r[6] ? cnt_ev1 : tick) & ~t1_wr & (m1 != 2'd3);
    assign th0_inc = t0_m3 & tick & tr1 & ~t0_wr;
    assign s0      = step(m0, tl0, th0);
    assign s1      = step(m1, tl1, th1);
    assign ovf0    = inc0 & s0[16];
    assign ovf1    = inc1 & s1[16];
    assign th0_ovf = th0_inc & (th0 == 8'hFF);

    // Hardware set beats a TCON write, which beats the interrupt acknowledge.
    always_comb begin
        tf0_nxt = ovf0 ? 1'b1 : tcon_wr ? sfr_wdata[5] : int_ack0 ? 1'b0 : tcon_r[5];
        tf1_nxt = (t0_m3 ? th0_ovf : ovf1) ? 1'b1 :
                  tcon_wr ? sfr_wdata[7] : int_ack1 ? 1'b0 : tcon_r[7];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcon_r  <= 8'h00;
            tmod_r  <= 8'h00;
            tl0     <= 8'h00;
            th0     <= 8'h00;
            tl1     <= 8'h00;
            th1     <= 8'h00;
            t1_ovf  <= 1'b0;
            t0_s    <= 2'b11;
            t1_s    <= 2'b11;
            i0_s    <= 2'b11;
            i1_s    <= 2'b11;
            t0_prev <= 1'b1;
            t1_prev <= 1'b1;
        end else begin
            t0_s <= {t0_s[0], t0_pin};
            t1_s <= {t1_s[0], t1_pin};
            i0_s <= {i0_s[0], int0_n};
            i1_s <= {i1_s[0], int1_n};
            if (tick) begin
                t0_prev <= t0_s[1];
                t1_prev <= t1_s[1];
            end
            t1_ovf <= ovf1;

            if (inc0) begin
                tl0 <= s0[7:0];
                if (!t0_m3) th0 <= s0[15:8];
            end
            if (th0_inc) th0 <= th0 + 8'd1;
            if (inc1) begin
                tl1 <= s1[7:0];
                th1 <= s1[15:8];
            end

            if (sfr_we) begin
                case (sfr_addr)
                    ADDR_TMOD: tmod_r <= sfr_wdata;
                    ADDR_TL0:  tl0    <= sfr_wdata;
                    ADDR_TH0:  th0    <= sfr_wdata;
                    ADDR_TL1:  tl1    <= sfr_wdata;
                    ADDR_TH1:  th1    <= sfr_wdata;
                    default: ;
                endcase
            end
            if (tcon_wr) tcon_r[6] <= sfr_wdata[6];
            if (tcon_wr) tcon_r[4:0] <= sfr_wdata[4:0];
            tcon_r[7] <= tf1_nxt;
            tcon_r[5] <= tf0_nxt;
        end
    end

    always_comb begin
        sfr_rdata = 8'h00;
        case (sfr_addr)
            ADDR_TCON: sfr_rdata = tcon_r;
            ADDR_TMOD: sfr_rdata = tmod_r;
            ADDR_TL0:  sfr_rdata = tl0;
            ADDR_TH0:  sfr_rdata = th0;
            ADDR_TL1:  sfr_rdata = tl1;
            ADDR_TH1:  sfr_rdata = th1;
            default:   sfr_rdata = 8'h00;
        endcase
    end

    assign tcon = tcon_r;
    assign tmod = tmod_r;

endmodule

// File: tb/tb_timer_counter01.sv
// tb/tb_timer_counter01.sv - directed self-checking bench for timer_counter01
module tb_timer_counter01;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       t0_pin = 1'b1, t1_pin = 1'b1, int0_n = 1'b1, int1_n = 1'b1;
    logic [7:0] sfr_addr = 8'h00, sfr_wdata = 8'h00;
    logic       sfr_we = 1'b0;
    logic [7:0] sfr_rdata;
    logic       int_ack0 = 1'b0, int_ack1 = 1'b0;
    logic [7:0] tcon, tmod;
    logic       t1_ovf;

    int total = 0;
    int bad = 0;
    int ovf_cnt = 0;
    logic [7:0] rd;

    timer_counter01 dut (
        .clk(clk), .reset(reset), .tick(tick),
        .t0_pin(t0_pin), .t1_pin(t1_pin), .int0_n(int0_n), .int1_n(int1_n),
        .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata), .sfr_we(sfr_we), .sfr_rdata(sfr_rdata),
        .int_ack0(int_ack0), .int_ack1(int_ack1),
        .tcon(tcon), .tmod(tmod), .t1_ovf(t1_ovf)
    );

    always #5 clk = ~clk;

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        sfr_addr = a; sfr_wdata = d; sfr_we = 1'b1;
        @(negedge clk);
        sfr_we = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
        sfr_addr = a;
        #1 d = sfr_rdata;
    endtask

    // One machine cycle: a tick then 11 idle clocks; t1_ovf sampled on every clock.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        if (t1_ovf) ovf_cnt++;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (t1_ovf) ovf_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tcon !== 8'h00) begin bad++; $display("FAIL reset_tcon got=%h exp=00", tcon); end
        total++; if (tmod !== 8'h00) begin bad++; $display("FAIL reset_tmod got=%h exp=00", tmod); end
        total++; if (t1_ovf !== 1'b0) begin bad++; $display("FAIL reset_t1ovf got=%b exp=0", t1_ovf); end
        for (int a = 8'h8A; a <= 8'h8D; a++) begin
            sfr_read(a[7:0], rd);
            total++; if (rd !== 8'h00) begin bad++; $display("FAIL reset_cnt addr=%h got=%h exp=00", a, rd); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mode1();
        sfr_write(8'h89, 8'h01);
        sfr_write(8'h8A, 8'hFE);
        sfr_write(8'h8C, 8'hFF);
        sfr_write(8'h88, 8'h10);
        do_tick();
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'hFF) begin bad++; $display("FAIL m1_tl0_t1 got=%h exp=ff", rd); end
        do_tick();
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL m1_tl0 got=%h exp=00", rd); end
        sfr_read(8'h8C, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL m1_th0 got=%h exp=00", rd); end
        total++; if (tcon !== 8'h30) begin bad++; $display("FAIL m1_tcon got=%h exp=30", tcon); end
        @(negedge clk); int_ack0 = 1'b1;
        @(negedge clk); int_ack0 = 1'b0;
        total++; if (tcon !== 8'h10) begin bad++; $display("FAIL m1_ack got=%h exp=10", tcon); end
    endtask

    task automatic test_mode2();
        sfr_write(8'h88, 8'h00);
        sfr_write(8'h89, 8'h20);
        sfr_write(8'h8D, 8'hF0);
        sfr_write(8'h8B, 8'hFF);
        sfr_write(8'h88, 8'h40);
        ovf_cnt = 0;
        do_tick();
        sfr_read(8'h8B, rd);
        total++; if (rd !== 8'hF0) begin bad++; $display("FAIL m2_reload got=%h exp=f0", rd); end
        total++; if (tcon !== 8'hC0) begin bad++; $display("FAIL m2_tcon got=%h exp=c0", tcon); end
        total++; if (ovf_cnt !== 1) begin bad++; $display("FAIL m2_ovf1 got=%0d exp=1", ovf_cnt); end
        ovf_cnt = 0;
        for (int i = 0; i < 15; i++) do_tick();
        sfr_read(8'h8B, rd);
        total++; if (rd !== 8'hFF || ovf_cnt !== 0) begin bad++; $display("FAIL m2_pre tl1=%h ovf=%0d exp=ff/0", rd, ovf_cnt); end
        do_tick();
        total++; if (ovf_cnt !== 1) begin bad++; $display("FAIL m2_ovf2 got=%0d exp=1", ovf_cnt); end
        sfr_read(8'h8D, rd);
        total++; if (rd !== 8'hF0) begin bad++; $display("FAIL m2_th1 got=%h exp=f0", rd); end
    endtask

    task automatic test_mode0();
        sfr_write(8'h88, 8'h00);
        sfr_write(8'h89, 8'h00);
        sfr_write(8'h8A, 8'h1F);
        sfr_write(8'h8C, 8'h00);
        sfr_write(8'h88, 8'h10);
        do_tick();
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL m0_tl0 got=%h exp=00", rd); end
        sfr_read(8'h8C, rd);
        total++; if (rd !== 8'h01) begin bad++; $display("FAIL m0_th0 got=%h exp=01", rd); end
        sfr_write(8'h8A, 8'hFF);
        do_tick();
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'hE0) begin bad++; $display("FAIL m0_upper got=%h exp=e0", rd); end
        sfr_read(8'h8C, rd);
        total++; if (rd !== 8'h02) begin bad++; $display("FAIL m0_th0b got=%h exp=02", rd); end
    endtask

    task automatic pin_edges(input int n);
        for (int i = 0; i < n; i++) begin
            t0_pin = 1'b0;
            do_tick();
            t0_pin = 1'b1;
            do_tick();
        end
    endtask

    task automatic test_counter_gate();
        sfr_write(8'h88, 8'h00);
        sfr_write(8'h89, 8'h0D);
        sfr_write(8'h8A, 8'h00);
        sfr_write(8'h8C, 8'h00);
        sfr_write(8'h88, 8'h10);
        int0_n = 1'b0;
        pin_edges(5);
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL gate_low got=%h exp=00", rd); end
        int0_n = 1'b1;
        pin_edges(5);
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h05) begin bad++; $display("FAIL gate_high got=%h exp=05", rd); end
        sfr_read(8'h8C, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL gate_th0 got=%h exp=00", rd); end
    endtask

    task automatic test_mode3();
        sfr_write(8'h88, 8'h00);
        sfr_write(8'h89, 8'h03);
        sfr_write(8'h8A, 8'h12);
        sfr_write(8'h8C, 8'hFF);
        sfr_write(8'h88, 8'h40);
        ovf_cnt = 0;
        do_tick();
        sfr_read(8'h8C, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL m3_th0 got=%h exp=00", rd); end
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h12) begin bad++; $display("FAIL m3_tl0 got=%h exp=12", rd); end
        total++; if (tcon !== 8'hC0) begin bad++; $display("FAIL m3_tcon got=%h exp=c0", tcon); end
        total++; if (ovf_cnt !== 0) begin bad++; $display("FAIL m3_t1ovf got=%0d exp=0", ovf_cnt); end
        sfr_read(8'h8B, rd);
        total++; if (rd !== 8'hF1) begin bad++; $display("FAIL m3_tl1 got=%h exp=f1", rd); end
    endtask

    task automatic test_collisions();
        sfr_write(8'h88, 8'h00);
        sfr_write(8'h89, 8'h01);
        sfr_write(8'h8A, 8'h10);
        sfr_write(8'h8C, 8'h20);
        sfr_write(8'h88, 8'h10);
        @(negedge clk);
        tick = 1'b1; sfr_addr = 8'h8A; sfr_wdata = 8'h55; sfr_we = 1'b1;
        @(negedge clk);
        tick = 1'b0; sfr_we = 1'b0;
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h55) begin bad++; $display("FAIL col_wr_tl0 got=%h exp=55", rd); end
        sfr_read(8'h8C, rd);
        total++; if (rd !== 8'h20) begin bad++; $display("FAIL col_wr_th0 got=%h exp=20", rd); end

        sfr_write(8'h8A, 8'hFF);
        sfr_write(8'h8C, 8'hFF);
        @(negedge clk);
        tick = 1'b1; int_ack0 = 1'b1;
        @(negedge clk);
        tick = 1'b0; int_ack0 = 1'b0;
        total++; if (tcon !== 8'h30) begin bad++; $display("FAIL col_ack got=%h exp=30", tcon); end

        do_tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (tcon !== 8'h00 || tmod !== 8'h00) begin bad++; $display("FAIL col_reset tcon=%h tmod=%h exp=00/00", tcon, tmod); end
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL col_reset_tl0 got=%h exp=00", rd); end
        @(negedge clk);
        reset = 1'b0;
        do_tick();
        sfr_read(8'h8A, rd);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL post_reset_tl0 got=%h exp=00", rd); end
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode2();
        test_mode0();
        test_counter_gate();
        test_mode3();
        test_collisions();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter01.md
# timer_counter01

Dual 8051 Timer/Counter unit (T0, T1) implementing modes 0–3, GATE and C/T control. It owns the TMOD, TL0, TH0, TL1 and TH1 SFRs plus TCON. It sits on the MCU SFR bus between the CPU's SFR decode and the interrupt controller. It produces TCON, whose TF0/TF1 flags feed interrupt generation, and a Timer-1 overflow strobe for the serial port.

## Interface
Parameters:
- ADDR_TCON, 8'h88, TCON SFR address
- ADDR_TMOD, 8'h89, TMOD SFR address
- ADDR_TL0 / ADDR_TL1 / ADDR_TH0 / ADDR_TH1, 8'h8A / 8'h8B / 8'h8C / 8'h8D, counter SFR addresses

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- tick  in  1  machine-cycle enable; one clk-wide pulse per machine cycle
- t0_pin, t1_pin  in  1  external count inputs; asynchronous
- int0_n, int1_n  in  1  external gate inputs; asynchronous
- sfr_addr  in  8  SFR address
- sfr_wdata  in  8  SFR write data
- sfr_we  in  1  SFR write strobe, one clk
- sfr_rdata  out  8  combinational read data for sfr_addr; 0 when the address does not match
- int_ack0, int_ack1  in  1  interrupt controller vectored to T0/T1; clears TF0/TF1
- tcon  out  8  TCON register {TF1,TR1,TF0,TR0,IE1,IT1,IE0,IT0}
- tmod  out  8  TMOD register {GATE1,CT1,M1_1,M0_1,GATE0,CT0,M1_0,M0_0}
- t1_ovf  out  1  one-clk pulse on every Timer-1 overflow (UART baud source)

## Operation
- Input conditioning: 2-flop synchronizer on t0_pin, t1_pin, int0_n, int1_n.
  - The counter-mode previous sample is updated only on tick.
  - Count event = tick AND prev_sample==1 AND sync==0 (falling edge between machine cycles).
- Run condition per timer: TRx AND (!GATEx OR intx_n_sync).
- Increment event: run AND (CTx ? count event : tick).
- Mode 0 (13-bit): TLx[4:0] is the prescaler.
  - TLx[4:0] wrap 1Fh→0 carries into THx.
  - THx wrap FFh→0 sets TFx.
  - TLx[7:5] hold their value and never increment.
- Mode 1 (16-bit): {THx,TLx} increments; FFFFh→0000h sets TFx.
- Mode 2 (8-bit auto-reload): TLx increments.
  - On FFh, TLx loads THx and TFx sets. THx is unchanged.
- Mode 3, Timer 0 only:
  - TL0 is an 8-bit counter using T0's run, GATE0 and CT0; it sets TF0.
  - TH0 is an 8-bit timer counting every tick while TR1=1; it sets TF1.
- Mode 3 for Timer 1: T1 holds its count.
- Timer 0 in mode 3:
  - T1 still runs in its own mode 0/1/2.
  - T1 does not set TF1, but t1_ovf still pulses.
- t1_ovf pulses on T1 overflow in any mode where T1 counts. It never pulses for TH0 overflow.
- TF clear sources: a TCON write, or int_ackx.
- TF flag priority (highest first):
  1. Hardware overflow set
  2. TCON SFR write
  3. int_ackx clear
- TCON[3:0]: plain storage written by SFR write. This block never modifies these bits.
- Counter SFR write vs increment in the same cycle:
  - The write wins, and the written byte takes the new value.
  - The other byte of the same timer keeps its value and does not increment that cycle.
  - A carry into a written byte is lost.
- TMOD write takes effect for the next increment event. Counts are not cleared on mode change.
- Reads return live register values.

## Timing
- Reset (async): TCON, TMOD, TL0, TH0, TL1 and TH1 are all 00h, and t1_ovf=0.
  - The synchronizers and previous samples reset to 1 (idle high).
- Reset asserted mid-count: registers clear immediately. Counting resumes on the first tick after reset releases, with TRx=0 until software sets it.
- The increment happens on the clk edge where tick=1. The overflow sets TFx on that same edge, so TFx is visible the cycle after the tick.
- t1_ovf is registered: high for exactly the one clk following the overflow edge.
- Pin-to-count latency: 2 clk of synchronization plus up to one machine cycle.
  - The minimum detectable pin high and low time is one machine cycle.
  - Falling-edge count rate is at most 1 per 2 machine cycles.
- sfr_rdata is combinational, with zero latency.
- A written value is readable from the clk after sfr_we.

## Test plan
- **Mode 1 overflow.** TMOD=01h, TL0=FEh, TH0=FFh, TR0=1, tick every 12 clk.
  - After tick 2, the count is 0000h, TF0=1 and tcon=30h.
  - int_ack0 then clears TF0.
- **Mode 2 auto-reload.** TMOD=20h, TH1=F0h, TL1=FFh, TR1=1.
  - On the next tick, TL1=F0h, TF1=1 and t1_ovf pulses for 1 clk.
  - After 16 more ticks a second t1_ovf pulse occurs.
- **Mode 0 prescale.** TMOD=00h, TL0=1Fh, TH0=00h.
  - One tick gives TL0[4:0]=00h, TH0=01h, with TL0[7:5] unchanged.
- **Counter mode and GATE.** TMOD=0Dh (GATE0=1, CT0=1, mode 1), TR0=1.
  - With int0_n=0: 5 t0_pin falling edges give TL0=00h.
  - With int0_n=1: 5 edges give TL0=05h.
- **Mode 3 split.** TMOD=03h, TR0=0, TR1=1, TH0=FFh.
  - One tick gives TH0=00h and TF1=1, while TL0 holds its value.
- **Collisions.**
  - SFR write TL0=55h on a tick edge while running: the read gives 55h.
  - Overflow in the same cycle as int_ack0: TF0 stays 1.
  - Reset asserted mid-run: all outputs read 00h.
